// File: rtl/cpu_pkg.sv
// Shared definitions for the 19-bit CPU.
//   XLEN          : machine word width
//   word_t        : one machine word (instruction or address)
//   fetch_state_e : instruction-fetch controller states
package cpu_pkg;

   localparam int XLEN = 19;

   typedef logic [XLEN-1:0] word_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/fetch_hold_reg.sv
// One-entry skid/hold register for the fetch stage. Parks the instruction
// that decode refused so the memory pipeline can keep moving.
// Ports:
//   clk, reset_n         : clock, async active-low reset
//   capture              : load d_instr/d_pc and mark the entry valid
//   flush                : drop the entry (wins over capture)
//   d_instr, d_pc        : instruction and its PC to park
//   hold_valid           : entry holds a live instruction
//   hold_instr, hold_pc  : parked instruction and its PC
module fetch_hold_reg
   import cpu_pkg::*;
(
   input  logic  clk,
   input  logic  reset_n,
   input  logic  capture,
   input  logic  flush,
   input  word_t d_instr,
   input  word_t d_pc,
   output logic  hold_valid,
   output word_t hold_instr,
   output word_t hold_pc
);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hold_valid <= 1'b0;
         hold_instr <= '0;
         hold_pc    <= '0;
      end else if (flush) begin
         hold_valid <= 1'b0;
      end else if (capture) begin
         hold_valid <= 1'b1;
         hold_instr <= d_instr;
         hold_pc    <= d_pc;
      end
   end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller. Owns the PC, presents it to instr_mem, tags
// the returning instruction with its PC, squashes wrong-path data after a
// redirect and absorbs decode stalls with a one-entry hold register.
// Ports:
//   clk, reset_n       : clock, async active-low reset
//   fetch_pc_o         : address to instr_mem
//   mem_instr_i        : instruction for the address presented last cycle
//   stall_i            : decode cannot take the current if_* instruction
//   redirect_valid_i   : branch/jump/resume request, target redirect_pc_i
//   halt_i             : decode accepted a HALT this cycle
//   if_valid_o         : if_instr_o / if_pc_o are valid
//   if_instr_o         : fetched instruction, 0 when not valid
//   if_pc_o            : PC of if_instr_o
//   halted_o           : controller is in HALT
//
// state | meaning
// IDLE  | first cycle out of reset, memory not yet requested
// RUN   | fetching one instruction per cycle
// HALT  | stopped after HALT; only a redirect (or reset) resumes
module fetch_ctrl
   import cpu_pkg::*;
#(
   parameter word_t RESET_PC = 19'h00000
) (
   input  logic  clk,
   input  logic  reset_n,
   output word_t fetch_pc_o,
   input  word_t mem_instr_i,
   input  logic  stall_i,
   input  logic  redirect_valid_i,
   input  word_t redirect_pc_i,
   input  logic  halt_i,
   output logic  if_valid_o,
   output word_t if_instr_o,
   output word_t if_pc_o,
   output logic  halted_o
);

   fetch_state_e state_q;
   word_t        pc_q;
   word_t        mem_pc_q;
   logic         inflight_q;
   logic         hold_valid_q;
   word_t        hold_instr_q;
   word_t        hold_pc_q;
   logic         hold_capture;
   logic         hold_flush;

   // Only park an instruction that is actually live on the memory port and
   // not already being consumed by a redirect or halt.
   assign hold_capture = stall_i & inflight_q & ~hold_valid_q
                         & ~redirect_valid_i & ~halt_i;
   assign hold_flush   = ~stall_i | redirect_valid_i | halt_i;

   fetch_hold_reg u_hold (
      .clk        (clk),
      .reset_n    (reset_n),
      .capture    (hold_capture),
      .flush      (hold_flush),
      .d_instr    (mem_instr_i),
      .d_pc       (mem_pc_q),
      .hold_valid (hold_valid_q),
      .hold_instr (hold_instr_q),
      .hold_pc    (hold_pc_q)
   );

   assign if_valid_o = hold_valid_q | inflight_q;
   assign if_pc_o    = hold_valid_q ? hold_pc_q : mem_pc_q;
   assign if_instr_o = !if_valid_o  ? '0
                     : hold_valid_q ? hold_instr_q
                     :                mem_instr_i;
   assign fetch_pc_o = pc_q;
   assign halted_o   = (state_q == HALT);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         pc_q       <= RESET_PC;
         mem_pc_q   <= '0;
         inflight_q <= 1'b0;
      end else begin
         mem_pc_q   <= pc_q;
         inflight_q <= (state_q == RUN) & ~redirect_valid_i & ~halt_i;
         case (state_q)
            IDLE: begin
               state_q <= RUN;
               if (redirect_valid_i) pc_q <= redirect_pc_i;
            end
            RUN: begin
               if (redirect_valid_i) begin
                  pc_q <= redirect_pc_i;
               end else if (halt_i) begin
                  state_q <= HALT;
               end else if (!(if_valid_o && stall_i)) begin
                  pc_q <= pc_q + word_t'(1);
               end
            end
            HALT: begin
               if (redirect_valid_i) begin
                  state_q <= RUN;
                  pc_q    <= redirect_pc_i;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule
